// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: integer register file read side with a busy-bit
// scoreboard, same-cycle writeback forwarding, RAW/WAW stall generation and
// a registered operand bundle handed to execute over valid/ready.
module operand_fetch_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    // decode side
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_src1,
    input  logic [ADDR_WIDTH-1:0] in_src2,
    input  logic [ADDR_WIDTH-1:0] in_dest,
    input  logic                  in_wr_en,
    input  logic                  in_wr_pair,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    // writeback side
    input  logic [1:0]            wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_value1,
    input  logic [DATA_WIDTH-1:0] wb_value2,
    // execute side
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_op1,
    output logic [DATA_WIDTH-1:0] out_op2,
    output logic [ADDR_WIDTH-1:0] out_dest,
    output logic                  out_wr_en,
    output logic                  out_wr_pair,
    output logic [CTRL_WIDTH-1:0] out_ctrl
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [DATA_WIDTH-1:0] wb_val [NREGS];   // value landing on each index this cycle
    logic [NREGS-1:0]      wb_hit;           // index written by writeback this cycle
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic [NREGS-1:0]      busy_eff;         // busy after same-cycle writeback exemption
    logic [NREGS-1:0]      busy_set;

    logic [ADDR_WIDTH-1:0] wb_dest_pair;
    logic [ADDR_WIDTH-1:0] in_dest_pair;
    logic                  hazard;
    logic                  accept;

    // Second register of a pair wraps modulo the register count.
    assign wb_dest_pair = wb_dest + ADDR_WIDTH'(1);
    assign in_dest_pair = in_dest + ADDR_WIDTH'(1);

    // Per-register writeback decode, busy tracking and storage. R0 is hard-wired:
    // it is never written and never becomes busy, even as the tail of a pair.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            localparam logic [ADDR_WIDTH-1:0] IDX   = ADDR_WIDTH'(gi);
            localparam bit                    IS_R0 = (gi == 0);
            logic hit_head;
            logic hit_tail;

            assign hit_head       = (wb_en != 2'b00) && (wb_dest == IDX);
            assign hit_tail       = (wb_en == 2'b11) && (wb_dest_pair == IDX);
            assign wb_hit[gi]     = !IS_R0 && (hit_head || hit_tail);
            // Head slot takes value1 unless only value2 is enabled; tail takes value2.
            assign wb_val[gi]     = (hit_head && wb_en[0]) ? wb_value1 : wb_value2;
            assign busy_eff[gi]   = busy_q[gi] && !wb_hit[gi];
            assign busy_set[gi]   = !IS_R0 && accept && in_wr_en &&
                                    ((in_dest == IDX) || (in_wr_pair && (in_dest_pair == IDX)));
            // A new reservation wins over a same-cycle writeback release.
            assign busy_d[gi]     = busy_eff[gi] || busy_set[gi];

            // Register storage: cleared on reset, loaded by writeback.
            always_ff @(posedge clock) begin
                if (reset) begin
                    regs_q[gi] <= '0;
                end else if (wb_hit[gi]) begin
                    regs_q[gi] <= wb_val[gi];
                end
            end
        end
    endgenerate

    // Busy-bit scoreboard: only writeback or reset release a reservation.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Source read with same-cycle writeback forwarding; R0 always reads zero.
    logic [DATA_WIDTH-1:0] op1_d;
    logic [DATA_WIDTH-1:0] op2_d;

    assign op1_d = (in_src1 == '0)   ? '0 :
                   wb_hit[in_src1]   ? wb_val[in_src1] : regs_q[in_src1];
    assign op2_d = (in_src2 == '0)   ? '0 :
                   wb_hit[in_src2]   ? wb_val[in_src2] : regs_q[in_src2];

    // RAW on either source, WAW on the destination (and its pair partner).
    assign hazard = busy_eff[in_src1] || busy_eff[in_src2] ||
                    (in_wr_en && (busy_eff[in_dest] || (in_wr_pair && busy_eff[in_dest_pair])));

    assign in_ready = !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_op1_q;
    logic [DATA_WIDTH-1:0] out_op2_q;
    logic [ADDR_WIDTH-1:0] out_dest_q;
    logic                  out_wr_en_q;
    logic                  out_wr_pair_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;

    // Output bundle: load on accept, hold while stalled, drop valid once drained.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_op1_q     <= '0;
            out_op2_q     <= '0;
            out_dest_q    <= '0;
            out_wr_en_q   <= 1'b0;
            out_wr_pair_q <= 1'b0;
            out_ctrl_q    <= '0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_op1_q     <= op1_d;
            out_op2_q     <= op2_d;
            out_dest_q    <= in_dest;
            out_wr_en_q   <= in_wr_en;
            out_wr_pair_q <= in_wr_pair;
            out_ctrl_q    <= in_ctrl;
        end else if (out_ready) begin
            out_valid_q   <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_op1     = out_op1_q;
    assign out_op2     = out_op2_q;
    assign out_dest    = out_dest_q;
    assign out_wr_en   = out_wr_en_q;
    assign out_wr_pair = out_wr_pair_q;
    assign out_ctrl    = out_ctrl_q;

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
Read side of the integer register file, sitting between decode and execute in the dual-result pipeline. It owns the 32-entry register array and a busy-bit scoreboard. It takes writeback traffic (single or paired writes) and reads two source operands, forwarding same-cycle writeback values. It stalls decode on RAW/WAW hazards and presents a registered operand bundle to execute over a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, register and operand width
ADDR_WIDTH, 5, register index width (2**ADDR_WIDTH entries)
CTRL_WIDTH, 8, opaque decode control bits passed through to execute

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage accepts instruction this cycle
in_src1  input  ADDR_WIDTH  source register 1
in_src2  input  ADDR_WIDTH  source register 2
in_dest  input  ADDR_WIDTH  destination register
in_wr_en  input  1  instruction writes in_dest
in_wr_pair  input  1  instruction also writes in_dest+1 (only with in_wr_en)
in_ctrl  input  CTRL_WIDTH  pass-through control
wb_en  input  2  bit0: write wb_value1 to wb_dest; bit1: write wb_value2 (see Behaviour)
wb_dest  input  ADDR_WIDTH  writeback destination
wb_value1  input  DATA_WIDTH  writeback value 1
wb_value2  input  DATA_WIDTH  writeback value 2
out_valid  output  1  operand bundle valid
out_ready  input  1  execute accepts bundle
out_op1  output  DATA_WIDTH  operand for src1
out_op2  output  DATA_WIDTH  operand for src2
out_dest  output  ADDR_WIDTH  registered in_dest
out_wr_en  output  1  registered in_wr_en
out_wr_pair  output  1  registered in_wr_pair
out_ctrl  output  CTRL_WIDTH  registered in_ctrl

Behaviour:
- Reset: all registers = 0, busy[] = 0, out_valid = 0; all out_* data fields = 0. Reset mid-handshake drops the bundle and all pending busy bits.
- Writeback decode: wb_en=01 -> R[wb_dest]=wb_value1; 10 -> R[wb_dest]=wb_value2; 11 -> R[wb_dest]=wb_value1 and R[wb_dest+1 mod 32]=wb_value2; 00 -> nothing. Each written index clears its busy bit.
- R0 reads as 0, is never written, and is never busy, including as the second register of a pair (dest=31 pairs to R0, which is ignored).
- Read with forwarding: the operand equals the same-cycle writeback value if that index is being written, otherwise R[src].
- Hazard: src_busy(s) = busy[s] and s not written by writeback this cycle. dest_busy = in_wr_en and (busy[in_dest], or in_wr_pair and busy[in_dest+1]), with the same writeback exemption.
- in_ready = ~hazard and (~out_valid or out_ready); it is combinational. hazard = src_busy(in_src1) or src_busy(in_src2) or dest_busy.
- Accept = in_valid and in_ready. The bundle is registered on the accept edge, giving 1-cycle latency to out_valid.
- On accept with in_wr_en, set busy[in_dest] (and busy[in_dest+1] if in_wr_pair), excluding R0. Set beats a same-cycle writeback clear of the same index.
- Output handshake: out_valid and all out_* fields hold stable while out_valid and ~out_ready. On out_ready with no new accept, out_valid goes to 0. Accept and drain in the same cycle (back-to-back) keeps out_valid = 1 and loads the new bundle.
- Busy bits are cleared only by writeback or reset. There is no flush.

Test Plan:
- Reset then write R5=0x1234 (wb_en=01). Next cycle, src1=5, src2=0 with out_ready=1 -> in_ready=1; next cycle out_valid=1, op1=0x1234, op2=0.
- Issue dest=3 with wr_en, then src1=3 -> in_ready=0 until wb_en=01, wb_dest=3, wb_value1=0xAA. In that same cycle in_ready=1, and next cycle op1=0xAA.
- Paired write wb_en=11, dest=31, value1=7, value2=9 -> R31=7; R0 still reads 0; busy[31] cleared.
- Hold out_ready=0 with out_valid=1 -> in_ready=0 and out_* stable for 3 cycles. Then assert out_ready with in_valid=1 -> back-to-back transfer with no bubble.
- WAW: issue dest=4, then a second instruction with dest=4 -> stalls until the R4 writeback. If the accept and a writeback clear of R4 coincide, busy[4] stays 1.
- Assert reset while out_valid=1 and busy[7]=1 -> next cycle out_valid=0, busy empty, and an instruction with src=7 is accepted immediately with op=0.
